z_frame_rx: RTL and testbench

- Downstream consumer of the 1-bit serial output `z` produced by the single-bit sequential stage.
- Hunts the `z` stream for a sync pattern, then deserializes DATA_W data bits MSB-first, followed by one even-parity bit.
- Parity-good words are pushed into a 2-entry output buffer and presented on a valid/ready interface.
- Parity errors and buffer overflows are counted in saturating counters.

---
 rtl/z_frame_pkg.sv | 22 ++
 rtl/z_frame_if.sv | 16 +
 rtl/z_frame_fifo2.sv | 71 +++++++
 rtl/z_frame_rx.sv | 127 ++++++++++++
 tb/tb_z_frame_rx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/z_frame_pkg.sv
// Shared types and defaults for the z-stream frame receiver.
// Holds the FSM state encoding, default frame geometry and the parity helper.
package z_frame_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int         DEF_DATA_W = 8;
  localparam int         DEF_SYNC_W = 4;
  localparam logic [3:0] DEF_SYNC   = 4'b1110;
  localparam int         DEF_CNT_W  = 8;
  localparam int         PAR_MAX_W  = 64;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_par_ok(input logic [PAR_MAX_W-1:0] word, input logic p);
    return ~(^word ^ p);
  endfunction

endpackage

// File: rtl/z_frame_if.sv
// Valid/ready word stream leaving the frame receiver.
// The master drives data/valid and holds them while ready is low.
interface z_frame_if
  import z_frame_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/z_frame_fifo2.sv
// Two-entry in-order FIFO; slot 0 is always the head, so pop_dat is a flop output.
// Push and pop may coincide at any occupancy; unused slots are held at zero.
module z_frame_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;

  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          slot0_d = push_dat;
          cnt_d   = 2'd1;
        end else if (cnt_q == 2'd1) begin
          slot1_d = push_dat;
          cnt_d   = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q != 2'd0) begin
          slot0_d = slot1_q;
          slot1_d = '0;
          cnt_d   = cnt_q - 2'd1;
        end
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever survives the pop.
        if (cnt_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = push_dat;
        end else begin
          slot0_d = push_dat;
          cnt_d   = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign pop_dat = slot0_q;
  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);

endmodule

// File: rtl/z_frame_rx.sv
// Hunts z for SYNC, deserializes DATA_W bits MSB-first plus even parity, buffers good words.
// Word appears two edges after the parity sample's cycle starts; a full buffer drops and counts.
module z_frame_rx
  import z_frame_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter int                SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = DEF_SYNC,
  parameter int                CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  z_frame_if.master        out_if,
  output logic             busy,
  output logic [CNT_W-1:0] parity_err_cnt,
  output logic [CNT_W-1:0] overflow_cnt
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [SYNC_W-1:0] hist_q, hist_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              done_q, done_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  perr_q, perr_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;

  logic [SYNC_W-1:0] hist_shift;
  logic              good;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dat;

  assign hist_shift = {hist_q[SYNC_W-2:0], z};
  assign pop        = !fifo_empty && out_if.out_ready;
  assign good       = done_q && even_par_ok(PAR_MAX_W'(word_q), par_q);
  assign push       = good && (!fifo_full || pop);

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    par_d     = par_q;
    word_d    = word_q;
    perr_d    = perr_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      HUNT: begin
        hist_d = hist_shift;
        if (hist_shift == SYNC) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      DATA: begin
        shreg_d   = {shreg_q[DATA_W-2:0], z};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(DATA_W - 1)) state_d = PARITY;
      end
      PARITY: begin
        // Frame verdict is registered and acted on next cycle, keeping z off every output path.
        done_d  = 1'b1;
        word_d  = shreg_q;
        par_d   = z;
        hist_d  = '0;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    if (done_q && !good && perr_q != CNT_MAX) perr_d = perr_q + CNT_W'(1);
    if (good && !push && ovf_q != CNT_MAX)    ovf_d  = ovf_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
      par_q     <= 1'b0;
      word_q    <= '0;
      perr_q    <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
      par_q     <= par_d;
      word_q    <= word_d;
      perr_q    <= perr_d;
      ovf_q     <= ovf_d;
    end
  end

  z_frame_fifo2 #(.W(DATA_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (word_q),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_if.out_data  = fifo_dat;
  assign out_if.out_valid = !fifo_empty;
  assign busy             = (state_q != HUNT);
  assign parity_err_cnt   = perr_q;
  assign overflow_cnt     = ovf_q;

endmodule

// File: tb/tb_z_frame_rx.sv
// Directed bench for z_frame_rx: a frame table plus hand-built backpressure, overlap, reset and saturation cases.
module tb_z_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       z;
  logic       busy, busy_s;
  logic [7:0] perr, ovf;
  logic [1:0] perr_s, ovf_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  z_frame_if #(.DATA_W(8)) o_if ();
  z_frame_if #(.DATA_W(8)) s_if ();

  z_frame_rx dut (
    .clk            (clk),
    .reset          (reset),
    .z              (z),
    .out_if         (o_if.master),
    .busy           (busy),
    .parity_err_cnt (perr),
    .overflow_cnt   (ovf)
  );

  z_frame_rx #(.CNT_W(2)) u_sat (
    .clk            (clk),
    .reset          (reset),
    .z              (z),
    .out_if         (s_if.master),
    .busy           (busy_s),
    .parity_err_cnt (perr_s),
    .overflow_cnt   (ovf_s)
  );

  typedef struct {
    logic [7:0] dat;
    logic       bad;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic [7:0] exp_perr;
    logic [7:0] exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    z = b;
    tick();
  endtask

  task automatic send_sync();
    logic [3:0] s;
    s = 4'b1110;
    for (int i = 3; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic send_body(input logic [7:0] d, input logic bad);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit((^d) ^ bad);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad);
    send_sync();
    send_body(d, bad);
  endtask

  initial begin
    vecs[0] = '{dat: 8'hA5, bad: 1'b0, exp_vld: 1'b1, exp_dat: 8'hA5, exp_perr: 8'd0, exp_ovf: 8'd0};
    vecs[1] = '{dat: 8'hA5, bad: 1'b1, exp_vld: 1'b0, exp_dat: 8'h00, exp_perr: 8'd1, exp_ovf: 8'd0};
    vecs[2] = '{dat: 8'h00, bad: 1'b0, exp_vld: 1'b1, exp_dat: 8'h00, exp_perr: 8'd1, exp_ovf: 8'd0};
    vecs[3] = '{dat: 8'hFF, bad: 1'b0, exp_vld: 1'b1, exp_dat: 8'hFF, exp_perr: 8'd1, exp_ovf: 8'd0};
    vecs[4] = '{dat: 8'h80, bad: 1'b0, exp_vld: 1'b1, exp_dat: 8'h80, exp_perr: 8'd1, exp_ovf: 8'd0};
    vecs[5] = '{dat: 8'h7F, bad: 1'b1, exp_vld: 1'b0, exp_dat: 8'h00, exp_perr: 8'd2, exp_ovf: 8'd0};

    reset = 1'b1;
    z = 1'b0;
    o_if.out_ready = 1'b0;
    s_if.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(o_if.out_valid), 32'd0);
    chk("rst_data", 32'(o_if.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    tick();

    o_if.out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_sync();
      chk($sformatf("v%0d_busy_data", v), 32'(busy), 32'd1);
      send_body(vecs[v].dat, vecs[v].bad);
      chk($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_not_early", v), 32'(o_if.out_valid), 32'd0);
      z = 1'b0;
      tick();
      chk($sformatf("v%0d_valid", v), 32'(o_if.out_valid), 32'(vecs[v].exp_vld));
      chk($sformatf("v%0d_data", v), 32'(o_if.out_data), 32'(vecs[v].exp_dat));
      chk($sformatf("v%0d_perr", v), 32'(perr), 32'(vecs[v].exp_perr));
      chk($sformatf("v%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
      tick();
      chk($sformatf("v%0d_drained", v), 32'(o_if.out_valid), 32'd0);
      chk($sformatf("v%0d_empty_data", v), 32'(o_if.out_data), 32'd0);
    end

    // Backpressure: third good frame finds the buffer full.
    o_if.out_ready = 1'b0;
    send_frame(8'h01, 1'b0);
    send_frame(8'h02, 1'b0);
    send_frame(8'h03, 1'b0);
    z = 1'b0;
    tick();
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_perr", 32'(perr), 32'd2);
    chk("bp_hold_valid", 32'(o_if.out_valid), 32'd1);
    chk("bp_hold_data", 32'(o_if.out_data), 32'h01);
    tick();
    chk("bp_still_01", 32'(o_if.out_data), 32'h01);
    o_if.out_ready = 1'b1;
    tick();
    chk("bp_pop2_valid", 32'(o_if.out_valid), 32'd1);
    chk("bp_pop2_data", 32'(o_if.out_data), 32'h02);
    tick();
    chk("bp_empty", 32'(o_if.out_valid), 32'd0);
    chk("bp_empty_data", 32'(o_if.out_data), 32'd0);

    // Overlapping sync 1,1,1,1,0 then data with an embedded 1110.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("ov_no_early_sync", 32'(busy), 32'd0);
    send_bit(1'b0);
    chk("ov_sync_on_zero", 32'(busy), 32'd1);
    send_body(8'hEE, 1'b0);
    chk("ov_busy_after", 32'(busy), 32'd0);
    z = 1'b0;
    tick();
    chk("ov_valid", 32'(o_if.out_valid), 32'd1);
    chk("ov_data", 32'(o_if.out_data), 32'hEE);
    tick();
    chk("ov_drained", 32'(o_if.out_valid), 32'd0);

    // Reset three bits into the data field.
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_valid", 32'(o_if.out_valid), 32'd0);
    chk("rm_perr", 32'(perr), 32'd0);
    chk("rm_ovf", 32'(ovf), 32'd0);
    send_frame(8'h3C, 1'b0);
    z = 1'b0;
    tick();
    chk("rm_valid_3c", 32'(o_if.out_valid), 32'd1);
    chk("rm_data_3c", 32'(o_if.out_data), 32'h3C);
    tick();
    chk("rm_drained", 32'(o_if.out_valid), 32'd0);
    chk("rm_perr_end", 32'(perr), 32'd0);
    chk("rm_ovf_end", 32'(ovf), 32'd0);

    // Saturation on the CNT_W=2 instance.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int f = 0; f < 5; f++) begin
      send_frame(8'h5A, 1'b1);
      z = 1'b0;
      tick();
      chk($sformatf("sat_f%0d", f), 32'(perr_s), (f < 3) ? 32'(f + 1) : 32'd3);
    end
    chk("sat_main_perr", 32'(perr), 32'd5);
    chk("sat_valid", 32'(s_if.out_valid), 32'd0);
    chk("sat_ovf", 32'(ovf_s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
